regfile_write_queue: RTL and testbench

//  Writer side of the 64x32 register file: buffers writeback requests from the

---
 rtl/regfile_write_queue.sv | 103 ++++++++++
 tb/tb_regfile_write_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: FIFO-buffered register file writeback with pending-write
// hazard lookup. Define WB_FORWARD_EN to enable newest-match data forwarding on
// fwd_data1/fwd_data2; otherwise those ports are tied to zero.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AW-1:0]          req_addr,
    input  logic [DW-1:0]          req_data,
    input  logic                   drain_stall,
    output logic [AW-1:0]          W,
    output logic [DW-1:0]          Data_in,
    output logic                   W_en,
    input  logic [AW-1:0]          q_addr1,
    input  logic [AW-1:0]          q_addr2,
    output logic                   hit1,
    output logic                   hit2,
    output logic [DW-1:0]          fwd_data1,
    output logic [DW-1:0]          fwd_data2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic push;
    logic pop;

    assign empty     = count == '0;
    assign full      = count == CW'(DEPTH);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = !empty && !drain_stall;

    // Queue storage, pointers, occupancy and the registered write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            vld     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            W       <= '0;
            Data_in <= '0;
            W_en    <= 1'b0;
        end else begin
            // push and pop never touch the same slot: that needs count 0 or DEPTH
            if (pop) begin
                W           <= addr_q[rd_ptr];
                Data_in     <= data_q[rd_ptr];
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (push) begin
                addr_q[wr_ptr] <= req_addr;
                data_q[wr_ptr] <= req_data;
                vld[wr_ptr]    <= 1'b1;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            W_en  <= pop;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Hazard: the output register is still pending until the file commits it.
    always_comb begin
        hit1 = W_en && (W == q_addr1);
        hit2 = W_en && (W == q_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 || (vld[i] && (addr_q[i] == q_addr1));
            hit2 = hit2 || (vld[i] && (addr_q[i] == q_addr2));
        end
    end

`ifdef WB_FORWARD_EN
    // Forwarding: walk from oldest to newest so the newest match wins.
    always_comb begin
        fwd_data1 = (W_en && (W == q_addr1)) ? Data_in : '0;
        fwd_data2 = (W_en && (W == q_addr2)) ? Data_in : '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_data1 = (vld[rd_ptr + PW'(i)] && (addr_q[rd_ptr + PW'(i)] == q_addr1)) ? data_q[rd_ptr + PW'(i)] : fwd_data1;
            fwd_data2 = (vld[rd_ptr + PW'(i)] && (addr_q[rd_ptr + PW'(i)] == q_addr2)) ? data_q[rd_ptr + PW'(i)] : fwd_data2;
        end
    end
`else
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed and random checks against a queue-based model.
module tb_regfile_write_queue;
    localparam int DEPTH = 4;
    localparam int AW = 6;
    localparam int DW = 32;

    logic clk = 0;
    logic reset_n = 0;
    logic req_valid = 0;
    logic req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic drain_stall = 0;
    logic [AW-1:0] W;
    logic [DW-1:0] Data_in;
    logic W_en;
    logic [AW-1:0] q_addr1 = '0;
    logic [AW-1:0] q_addr2 = '0;
    logic hit1, hit2;
    logic [DW-1:0] fwd_data1, fwd_data2;
    logic [$clog2(DEPTH):0] count;
    logic empty, full;

    regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .drain_stall(drain_stall),
        .W(W), .Data_in(Data_in), .W_en(W_en), .q_addr1(q_addr1), .q_addr2(q_addr2),
        .hit1(hit1), .hit2(hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    logic [AW-1:0] m_w = '0;
    logic [DW-1:0] m_d = '0;
    logic m_wen = 0;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Newest pending write to an address: scan oldest to newest, last match wins.
    task automatic exp_hz(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
        h = 0;
        d = '0;
        if (m_wen && m_w == a) begin
            h = 1;
            d = m_d;
        end
        foreach (mq[i]) if (mq[i].a == a) begin
            h = 1;
            d = mq[i].d;
        end
`ifndef WB_FORWARD_EN
        d = '0;
`endif
    endtask

    task automatic check_all();
        logic h;
        logic [DW-1:0] d;
        chk("W", W, m_w);
        chk("Data_in", Data_in, m_d);
        chk("W_en", W_en, m_wen);
        chk("count", count, 64'(mq.size()));
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEPTH);
        chk("req_ready", req_ready, mq.size() < DEPTH);
        exp_hz(q_addr1, h, d);
        chk("hit1", hit1, h);
        chk("fwd_data1", fwd_data1, d);
        exp_hz(q_addr2, h, d);
        chk("hit2", hit2, h);
        chk("fwd_data2", fwd_data2, d);
    endtask

    // One clock edge: model pops the head then appends an accepted request.
    task automatic tick();
        bit pu;
        bit po;
        ent_t e;
        pu = req_valid && mq.size() < DEPTH;
        po = mq.size() > 0 && !drain_stall;
        e.a = req_addr;
        e.d = req_data;
        @(posedge clk);
        m_wen = po;
        if (po) begin
            m_w = mq[0].a;
            m_d = mq[0].d;
            void'(mq.pop_front());
        end
        if (pu) mq.push_back(e);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        mq.delete();
        m_w = '0;
        m_d = '0;
        m_wen = 0;
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    initial begin
        // reset from time zero
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1;
        tick();

        // single write r5
        req_valid = 1; req_addr = 5; req_data = 32'hDEADBEEF;
        tick();
        req_valid = 0;
        tick();
        chk("single_W", W, 5);
        chk("single_D", Data_in, 32'hDEADBEEF);
        chk("single_en", W_en, 1);
        tick();
        chk("single_en_off", W_en, 0);
        chk("single_empty", empty, 1);

        // fill, overflow attempt, drain; repeated to wrap the pointers
        for (int r = 0; r < 3; r++) begin
            drain_stall = 1;
            for (int k = 1; k <= 4; k++) begin
                req_valid = 1; req_addr = AW'(k); req_data = 32'h100 * r + k;
                tick();
            end
            req_addr = 9; req_data = 32'hBAD;
            tick();
            chk("fill_full", full, 1);
            chk("fill_ready", req_ready, 0);
            req_valid = 0; drain_stall = 0;
            for (int k = 1; k <= 4; k++) begin
                tick();
                chk("fill_W", W, k);
                chk("fill_D", Data_in, 32'h100 * r + k);
                chk("fill_en", W_en, 1);
            end
            tick();
            chk("fill_done", W_en, 0);
        end

        // sustained push+pop
        req_valid = 1; req_addr = 10; req_data = $urandom;
        tick();
        for (int k = 0; k < 20; k++) begin
            req_addr = AW'(11 + k); req_data = $urandom;
            tick();
            chk("sim_count", count, 1);
            chk("sim_W", W, 10 + k);
        end
        req_valid = 0;
        tick();
        tick();

        // hazard priority: two pending writes to r7
        drain_stall = 1; q_addr1 = 7; q_addr2 = 8;
        req_valid = 1; req_addr = 7; req_data = 32'h11;
        tick();
        req_data = 32'h22;
        tick();
        req_valid = 0;
        #1;
        chk("hz_hit1", hit1, 1);
        chk("hz_hit2", hit2, 0);
`ifdef WB_FORWARD_EN
        chk("hz_fwd1", fwd_data1, 32'h22);
`else
        chk("hz_fwd1", fwd_data1, 0);
`endif
        do_reset();

        // output-register hit: r7 popped while queue holds only r9
        req_valid = 1; req_addr = 7; req_data = 32'h11;
        tick();
        req_addr = 9; req_data = 32'h33;
        tick();
        req_valid = 0; drain_stall = 1;
        tick();
        drain_stall = 0;
        tick();
        drain_stall = 1;
        chk("oreg_hit", hit1, 1);
`ifdef WB_FORWARD_EN
        chk("oreg_fwd", fwd_data1, 32'h11);
`else
        chk("oreg_fwd", fwd_data1, 0);
`endif
        tick();
        chk("oreg_clear", hit1, 0);

        // reset mid-traffic drops queued writes
        req_valid = 1; req_addr = 3; req_data = 32'h77;
        tick();
        tick();
        req_valid = 0;
        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_ready", req_ready, 1);
        drain_stall = 0;
        tick();
        chk("rst_nopulse", W_en, 0);
        tick();

        // random traffic with one asynchronous reset
        for (int n = 0; n < 400; n++) begin
            req_valid = $urandom_range(0, 3) != 0;
            req_addr = AW'($urandom_range(0, 7));
            req_data = $urandom;
            drain_stall = $urandom_range(0, 2) == 0;
            q_addr1 = AW'($urandom_range(0, 7));
            q_addr2 = AW'($urandom_range(0, 7));
            if (n == 200) do_reset();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
